// File: rtl/seg_code_sequencer.sv
// Display-code source for the single-digit 7-segment decoder: held value, up/down hex counter or message scroll.
// Optional macro HOLD_BLINK_EN: blank toggles on each tick while in HOLD (otherwise blank is tied low).
module seg_code_sequencer #(
  parameter int unsigned DIV_MAX   = 999999,
  parameter int unsigned DIV_WIDTH = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [1:0] mode,
  input  logic [3:0] data_in,
  input  logic       load,
  output logic [4:0] code,
  output logic       step,
  output logic       dp,
  output logic       blank
);

  typedef enum logic [1:0] {
    ST_HOLD = 2'b00,
    ST_UP   = 2'b01,
    ST_MSG  = 2'b10,
    ST_DN   = 2'b11
  } state_t;

  localparam logic [DIV_WIDTH-1:0] DIV_TC = DIV_WIDTH'(DIV_MAX);

  state_t               state_reg, state_next;
  logic [1:0]           mode_q;
  logic [DIV_WIDTH-1:0] div_reg, div_next;
  logic [4:0]           code_reg, code_next;
  logic                 dp_reg, dp_next;
  logic                 step_reg;
  logic                 tick, mode_chg, load_ok;

  assign tick     = ena && (div_reg == DIV_TC);
  assign mode_chg = (mode != mode_q);
  // The message scroll has no editable value, so load is ignored there.
  assign load_ok  = load && (state_reg != ST_MSG);

  always_comb begin
    state_next = state_reg;
    code_next  = code_reg;
    dp_next    = dp_reg;
    div_next   = div_reg;
    if (ena) begin
      div_next = tick ? '0 : div_reg + DIV_WIDTH'(1);
    end
    if (mode_chg) begin
      state_next = state_t'(mode);
      code_next  = (state_t'(mode) == ST_MSG) ? 5'h10 : {1'b0, data_in};
      dp_next    = 1'b0;
      div_next   = '0;
    end else if (load_ok) begin
      code_next = {1'b0, data_in};
      dp_next   = 1'b0;
      div_next  = '0;
    end else if (tick) begin
      // dp marks the wrap step and is rewritten on every tick, so it lasts one step.
      case (state_reg)
        ST_UP: begin
          code_next = {1'b0, code_reg[3:0] + 4'd1};
          dp_next   = (code_reg[3:0] == 4'hF);
        end
        ST_DN: begin
          code_next = {1'b0, code_reg[3:0] - 4'd1};
          dp_next   = (code_reg[3:0] == 4'h0);
        end
        ST_MSG: begin
          code_next = {1'b1, code_reg[3:0] + 4'd1};
          dp_next   = (code_reg[3:0] == 4'hE);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_HOLD;
      mode_q    <= 2'b00;
      div_reg   <= '0;
      code_reg  <= 5'h10;
      dp_reg    <= 1'b0;
      step_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      mode_q    <= mode;
      div_reg   <= div_next;
      code_reg  <= code_next;
      dp_reg    <= dp_next;
      step_reg  <= (code_next != code_reg);
    end
  end

  assign code = code_reg;
  assign dp   = dp_reg;
  assign step = step_reg;

`ifdef HOLD_BLINK_EN
  logic blank_reg, blank_next;

  // A load consumes the coincident tick, so it does not toggle the blink.
  always_comb begin
    blank_next = blank_reg;
    if (mode_chg || (state_reg != ST_HOLD)) begin
      blank_next = 1'b0;
    end else if (tick && !load) begin
      blank_next = ~blank_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_reg <= 1'b0;
    end else begin
      blank_reg <= blank_next;
    end
  end

  assign blank = blank_reg;
`else
  assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_seg_code_sequencer.sv
// Directed bench for seg_code_sequencer (DIV_MAX=3): expected {dp,code} per step pulse are queued as stimulus is driven.
// Honours HOLD_BLINK_EN the same way the design does.
module tb_seg_code_sequencer;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       ena     = 1'b0;
  logic [1:0] mode    = 2'b00;
  logic [3:0] data_in = 4'h0;
  logic       load    = 1'b0;
  logic [4:0] code;
  logic       step;
  logic       dp;
  logic       blank;

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q[$];

  seg_code_sequencer #(
    .DIV_MAX  (3),
    .DIV_WIDTH(4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .mode   (mode),
    .data_in(data_in),
    .load   (load),
    .code   (code),
    .step   (step),
    .dp     (dp),
    .blank  (blank)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [4:0] c, input logic d);
    exp_q.push_back({d, c});
  endtask

  // Waits (bounded) for the next step pulse, then pops and compares code/dp and the latency in cycles.
  task automatic wait_step(input string tag, input int exp_n);
    int n;
    bit seen;
    logic [5:0] e;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 12) begin
      @(negedge clk);
      n++;
      seen = (step === 1'b1);
      load = 1'b0;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 6'h3F;
      check({tag, "_code"}, 32'(code), 32'(e[4:0]));
      check({tag, "_dp"}, 32'(dp), 32'(e[5]));
      check({tag, "_lat"}, n, exp_n);
      $display("step %s: code=%02h dp=%0b after %0d cycles", tag, code, dp, n);
    end
  endtask

  initial begin
    int nsteps;
    logic exp_blank;

    // Power-on reset
    @(negedge clk);
    check("rst_code", 32'(code), 32'h10);
    check("rst_step", 32'(step), 32'd0);
    check("rst_dp", 32'(dp), 32'd0);
    check("rst_blank", 32'(blank), 32'd0);
    rst_n = 1'b1;

    // Count up through the F->0 wrap
    mode = 2'b01; data_in = 4'hE; ena = 1'b1;
    push(5'h0E, 1'b0); push(5'h0F, 1'b0); push(5'h00, 1'b1); push(5'h01, 1'b0); push(5'h02, 1'b0);
    wait_step("up_entry", 1);
    wait_step("up_t1", 4);
    wait_step("up_wrap", 4);
    wait_step("up_t3", 4);
    wait_step("up_t4", 4);

    // Count down through the 0->F wrap, then freeze
    mode = 2'b11; data_in = 4'h1;
    push(5'h01, 1'b0); push(5'h00, 1'b0); push(5'h0F, 1'b1);
    wait_step("dn_entry", 1);
    wait_step("dn_t1", 4);
    wait_step("dn_wrap", 4);
    ena = 1'b0;
    nsteps = 0;
    repeat (20) begin
      @(negedge clk);
      if (step === 1'b1) nsteps++;
    end
    check("freeze_steps", nsteps, 0);
    check("freeze_code", 32'(code), 32'h0F);
    check("freeze_dp", 32'(dp), 32'd1);

    // Message scroll with an ignored load
    ena = 1'b1; mode = 2'b10;
    push(5'h10, 1'b0);
    for (int i = 1; i <= 15; i++) push({1'b1, 4'(i)}, (i == 15));
    push(5'h10, 1'b0);
    wait_step("msg_entry", 1);
    for (int i = 1; i <= 16; i++) begin
      if (i == 3) begin
        @(negedge clk);
        check("msg_idle_a", 32'(step), 32'd0);
        @(negedge clk);
        check("msg_idle_b", 32'(step), 32'd0);
        load = 1'b1; data_in = 4'h5;
        @(negedge clk);
        check("msg_load_ignored", 32'(step), 32'd0);
        load = 1'b0;
        wait_step($sformatf("msg_t%0d", i), 1);
      end else begin
        wait_step($sformatf("msg_t%0d", i), 4);
      end
    end

    // Load colliding with a tick, then loads between ticks
    mode = 2'b01; data_in = 4'h3;
    push(5'h03, 1'b0);
    wait_step("ld_entry", 1);
    repeat (3) @(negedge clk);
    load = 1'b1; data_in = 4'h7;
    push(5'h07, 1'b0);
    wait_step("ld_collide", 1);
    push(5'h08, 1'b0);
    wait_step("ld_next", 4);
    @(negedge clk);
    load = 1'b1; data_in = 4'hC;
    push(5'h0C, 1'b0);
    wait_step("ld_mid", 1);
    push(5'h0D, 1'b0);
    wait_step("ld_mid_next", 4);
    load = 1'b1; data_in = 4'hD;
    @(negedge clk);
    load = 1'b0;
    check("ld_same_nostep", 32'(step), 32'd0);
    check("ld_same_code", 32'(code), 32'h0D);
    push(5'h0E, 1'b0);
    wait_step("ld_same_next", 4);

    // HOLD: load, blink cadence, exit clears blank
    mode = 2'b00; data_in = 4'h9;
    push(5'h09, 1'b0);
    wait_step("hold_entry", 1);
    load = 1'b1; data_in = 4'hA;
    push(5'h0A, 1'b0);
    wait_step("hold_load", 1);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
`ifdef HOLD_BLINK_EN
      exp_blank = ((i / 4) % 2) == 1;
`else
      exp_blank = 1'b0;
`endif
      check($sformatf("hold_blank_c%0d", i), 32'(blank), 32'(exp_blank));
      check($sformatf("hold_nostep_c%0d", i), 32'(step), 32'd0);
    end
    check("hold_code", 32'(code), 32'h0A);
    mode = 2'b01; data_in = 4'h3;
    push(5'h03, 1'b0);
    wait_step("hold_exit", 1);
    check("hold_exit_blank", 32'(blank), 32'd0);

    // Asynchronous reset mid-operation while step and dp are high
    mode = 2'b11; data_in = 4'h0;
    push(5'h00, 1'b0); push(5'h0F, 1'b1);
    wait_step("dn2_entry", 1);
    wait_step("dn2_wrap", 4);
    #2 rst_n = 1'b0;
    #1;
    check("arst_code", 32'(code), 32'h10);
    check("arst_step", 32'(step), 32'd0);
    check("arst_dp", 32'(dp), 32'd0);
    check("arst_blank", 32'(blank), 32'd0);
    @(negedge clk);
    data_in = 4'h5;
    rst_n = 1'b1;
    push(5'h05, 1'b0);
    wait_step("rel_entry", 1);

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
